// File: rtl/blink_pkg.sv
// blink_pkg: rate selects, 25 MHz half-period defaults and FSM encoding shared by the blink chain.
package blink_pkg;
  localparam logic [1:0] RATE_10HZ = 2'd0;
  localparam logic [1:0] RATE_5HZ  = 2'd1;
  localparam logic [1:0] RATE_2HZ  = 2'd2;
  localparam logic [1:0] RATE_1HZ  = 2'd3;
  localparam int HP_10HZ_25M = 1250000;
  localparam int HP_5HZ_25M  = 2500000;
  localparam int HP_2HZ_25M  = 6250000;
  localparam int HP_1HZ_25M  = 12500000;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;
endpackage

// File: rtl/blink_sync_2ff.sv
// blink_sync_2ff: W-bit two-flop synchronizer with asynchronous active-high reset.
module blink_sync_2ff #(
  parameter int W = 1
) (
  input  logic         i_Clk,
  input  logic         i_Rst,
  input  logic [W-1:0] i_D,
  output logic [W-1:0] o_Q
);
  logic [W-1:0] meta;
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) {o_Q, meta} <= '0;
    else {o_Q, meta} <= {meta, i_D};
endmodule

// File: rtl/blink_toggle_gen.sv
// blink_toggle_gen: rate-selectable square wave with a flip tick for the blink LED demux.
// Define BLINK_TOGGLE_SYNC_EN to pass i_Enable/i_Rate_Sel through a 2-flop synchronizer.
module blink_toggle_gen import blink_pkg::*; #(
  parameter int HALF_PERIOD_0 = HP_10HZ_25M,
  parameter int HALF_PERIOD_1 = HP_5HZ_25M,
  parameter int HALF_PERIOD_2 = HP_2HZ_25M,
  parameter int HALF_PERIOD_3 = HP_1HZ_25M
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Enable,
  input  logic [1:0] i_Rate_Sel,
  output logic       o_Toggle,
  output logic       o_Tick,
  output logic       o_Active
);
  localparam int CW = $clog2(HALF_PERIOD_3);
  localparam logic [CW-1:0] T0 = CW'(HALF_PERIOD_0 - 1);
  localparam logic [CW-1:0] T1 = CW'(HALF_PERIOD_1 - 1);
  localparam logic [CW-1:0] T2 = CW'(HALF_PERIOD_2 - 1);
  localparam logic [CW-1:0] T3 = CW'(HALF_PERIOD_3 - 1);
  if (HALF_PERIOD_0 < 2 || HALF_PERIOD_1 < 2 || HALF_PERIOD_2 < 2 || HALF_PERIOD_3 < 2 ||
      HALF_PERIOD_3 < HALF_PERIOD_0 || HALF_PERIOD_3 < HALF_PERIOD_1 || HALF_PERIOD_3 < HALF_PERIOD_2) begin : g_bad_hp
    $error("blink_toggle_gen: half-periods must be >= 2 and HALF_PERIOD_3 the largest");
  end
  logic [2:0] in_q;
  logic en;
  logic [1:0] sel;
`ifdef BLINK_TOGGLE_SYNC_EN
  blink_sync_2ff #(.W(3)) u_sync (
    .i_Clk(i_Clk),
    .i_Rst(i_Rst),
    .i_D({i_Enable, i_Rate_Sel}),
    .o_Q(in_q)
  );
`else
  assign in_q = {i_Enable, i_Rate_Sel};
`endif
  assign {en, sel} = in_q;
  logic [0:0] state;
  logic [1:0] rate;
  logic [CW-1:0] cnt, term;
  logic wrap;
  always_comb begin
    term = rate == RATE_10HZ ? T0 : rate == RATE_5HZ ? T1 : rate == RATE_2HZ ? T2 : T3;
    wrap = cnt == term;
  end
  assign o_Active = state == ST_RUN;
  // Rate is only re-latched at a flip so a half-period in progress is never cut or stretched.
  always_ff @(posedge i_Clk or posedge i_Rst)
    if (i_Rst) begin
      state    <= ST_IDLE;
      rate     <= RATE_10HZ;
      cnt      <= '0;
      o_Toggle <= 1'b0;
      o_Tick   <= 1'b0;
    end else if (state == ST_IDLE || !en) begin
      cnt      <= '0;
      o_Toggle <= 1'b0;
      o_Tick   <= 1'b0;
      state    <= state == ST_IDLE && en ? ST_RUN : ST_IDLE;
      if (state == ST_IDLE && en) rate <= sel;
    end else begin
      o_Tick <= wrap;
      cnt    <= wrap ? '0 : cnt + 1'b1;
      if (wrap) begin
        o_Toggle <= ~o_Toggle;
        rate     <= sel;
      end
    end
endmodule

// File: tb/tb_blink_toggle_gen.sv
// tb_blink_toggle_gen: vector table plus scoreboard queue for blink_toggle_gen with half-periods 2/3/5/8.
module tb_blink_toggle_gen;
`ifdef BLINK_TOGGLE_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif
  localparam int HP [4] = '{2, 3, 5, 8};
  typedef struct {logic en; logic [1:0] sel; logic tog, tick, act;} vec_t;
  typedef struct {logic tog, tick, act; int id;} exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [1:0] sel = 2'd0;
  logic tog, tick, act;
  exp_t sbq[$];
  vec_t vt [19];
  int tests = 0, fails = 0, sid = 0;
  logic prev_tick = 1'b0, exp_tog = 1'b0;
  blink_toggle_gen #(.HALF_PERIOD_0(2), .HALF_PERIOD_1(3), .HALF_PERIOD_2(5), .HALF_PERIOD_3(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Enable(en), .i_Rate_Sel(sel),
    .o_Toggle(tog), .o_Tick(tick), .o_Active(act)
  );
  always #5 clk = ~clk;
  task automatic sample();
    @(posedge clk);
    #1;
    tests++;
    if (tick && (!act || prev_tick)) begin
      fails++;
      $display("FAIL tick_rule t=%0t: tick=%b prev_tick=%b active=%b, required no tick in IDLE or back-to-back", $time, tick, prev_tick, act);
    end
    prev_tick = tick;
  endtask
  task automatic step(input logic e, input logic [1:0] s, input logic et, input logic ek, input logic ea);
    exp_t x;
    en = e;
    sel = s;
    sbq.push_back('{et, ek, ea, sid});
    sid++;
    sample();
    if (sbq.size() > LAT) begin
      x = sbq.pop_front();
      tests++;
      if ({tog, tick, act} !== {x.tog, x.tick, x.act}) begin
        fails++;
        $display("FAIL step%0d: tog/tick/act=%b%b%b required %b%b%b", x.id, tog, tick, act, x.tog, x.tick, x.act);
      end
    end
  endtask
  task automatic prime();
    sbq.delete();
    repeat (LAT) sbq.push_back('{1'b0, 1'b0, 1'b0, -1});
  endtask
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) step(vt[i].en, vt[i].sel, vt[i].tog, vt[i].tick, vt[i].act);
  endtask
  // One half-period of hp clocks in RUN; select switches from s0 to s1 after chg clocks.
  task automatic seg(input int hp, input logic [1:0] s0, input logic [1:0] s1, input int chg);
    for (int i = 1; i <= hp; i++) begin
      if (i == hp) exp_tog = ~exp_tog;
      step(1'b1, i > chg ? s1 : s0, exp_tog, i == hp, 1'b1);
    end
  endtask
  initial begin
    int ticks;
    vt = '{
      '{1, 0, 0, 0, 1}, '{1, 0, 0, 0, 1}, '{1, 0, 1, 1, 1}, '{1, 0, 1, 0, 1},
      '{1, 0, 0, 1, 1}, '{1, 0, 0, 0, 1}, '{1, 0, 1, 1, 1},
      '{1, 0, 1, 0, 1}, '{0, 0, 0, 0, 0}, '{1, 1, 0, 0, 1}, '{1, 1, 0, 0, 1},
      '{1, 1, 0, 0, 1}, '{1, 1, 1, 1, 1}, '{0, 1, 0, 0, 0}, '{1, 0, 0, 0, 1},
      '{1, 0, 0, 0, 1}, '{1, 0, 1, 1, 1}, '{0, 0, 0, 0, 0}, '{0, 0, 0, 0, 0}
    };
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({tog, tick, act} !== 3'b000) begin
      fails++;
      $display("FAIL reset_state: tog/tick/act=%b%b%b required 000", tog, tick, act);
    end
    rst = 1'b0;
    prime();
    run_vecs(0, 18);
    step(1'b1, 2'd3, 1'b0, 1'b0, 1'b1);
    exp_tog = 1'b0;
    seg(8, 2'd3, 2'd3, 0);
    seg(8, 2'd3, 2'd1, 3);
    repeat (3) seg(3, 2'd1, 2'd1, 0);
    step(1'b0, 2'd1, 1'b0, 1'b0, 1'b0);
    exp_tog = 1'b0;
    repeat (5) step(1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
    tests++;
    if (act !== 1'b1) begin
      fails++;
      $display("FAIL pre_reset_active: active=%b required 1", act);
    end
    #3 rst = 1'b1;
    #1;
    tests++;
    if ({tog, tick, act} !== 3'b000) begin
      fails++;
      $display("FAIL async_reset: tog/tick/act=%b%b%b required 000 before next edge", tog, tick, act);
    end
    en = 1'b0;
    sel = 2'd0;
    @(posedge clk);
    #3 rst = 1'b0;
    prime();
    run_vecs(0, 6);
    en = 1'b0;
    repeat (LAT + 2) sample();
    for (int s = 0; s < 4; s++) begin
      ticks = 0;
      en = 1'b1;
      sel = 2'(s);
      repeat (200) begin
        sample();
        ticks += int'(tick);
      end
      en = 1'b0;
      repeat (LAT + 2) begin
        sample();
        ticks += int'(tick);
      end
      tests++;
      if (ticks != 199 / HP[s] || act !== 1'b0) begin
        fails++;
        $display("FAIL tick_count_sel%0d: ticks=%0d active=%b required ticks=%0d active=0", s, ticks, act, 199 / HP[s]);
      end
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
